// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single outstanding word reads, buffers results.
// Define FETCH_PREFETCH_EN for a two-entry queue that prefetches one word ahead.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_ADDRESS = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        memory_read_request,
    output logic [15:0] memory_address,
    input  logic        memory_read_valid,
    input  logic [15:0] memory_read_data,
    output logic        instruction_valid,
    input  logic        instruction_take,
    output logic [3:0]  instruction_operation,
    output logic [3:0]  instruction_destination,
    output logic [3:0]  instruction_operation_extra,
    output logic [3:0]  instruction_source,
    output logic [7:0]  instruction_immediate,
    output logic [15:0] instruction_address,
    input  logic        redirect,
    input  logic [15:0] redirect_address
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        stale_q, stale_d;
    logic [1:0]  count_q, count_d;
    logic        req_q, req_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] head_word_q, head_word_d;
    logic [15:0] head_addr_q, head_addr_d;
`ifdef FETCH_PREFETCH_EN
    logic [15:0] tail_word_q, tail_word_d;
    logic [15:0] tail_addr_q, tail_addr_d;
`endif

    logic       pop;
    logic       returning;
    logic       push;
    logic       issue;
    logic [1:0] kept;

    assign pop       = instruction_take && (count_q != 2'd0);
    assign returning = memory_read_valid && outstanding_q;
    assign push      = returning && !stale_q;
    assign issue     = !outstanding_q && (count_q < DEPTH);
    assign kept      = count_q - {1'b0, pop};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        count_d       = count_q;
        req_d         = 1'b0;
        req_addr_d    = req_addr_q;
        head_word_d   = head_word_q;
        head_addr_d   = head_addr_q;
`ifdef FETCH_PREFETCH_EN
        tail_word_d   = tail_word_q;
        tail_addr_d   = tail_addr_q;
`endif
        if (redirect) begin
            // A read still in flight must be swallowed when it lands.
            count_d       = 2'd0;
            fetch_pc_d    = redirect_address;
            outstanding_d = outstanding_q && !memory_read_valid;
            stale_d       = outstanding_q && !memory_read_valid;
        end else begin
            if (returning) begin
                outstanding_d = 1'b0;
                stale_d       = 1'b0;
            end
            if (issue) begin
                req_d         = 1'b1;
                req_addr_d    = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd1;
                outstanding_d = 1'b1;
            end
`ifdef FETCH_PREFETCH_EN
            if (pop && (count_q == 2'd2)) begin
                head_word_d = tail_word_q;
                head_addr_d = tail_addr_q;
            end
            if (push) begin
                if (kept == 2'd0) begin
                    head_word_d = memory_read_data;
                    head_addr_d = req_addr_q;
                end else begin
                    tail_word_d = memory_read_data;
                    tail_addr_d = req_addr_q;
                end
            end
`else
            if (push) begin
                head_word_d = memory_read_data;
                head_addr_d = req_addr_q;
            end
`endif
            count_d = kept + {1'b0, push};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_ADDRESS;
            outstanding_q <= 1'b0;
            stale_q       <= 1'b0;
            count_q       <= 2'd0;
            req_q         <= 1'b0;
            req_addr_q    <= 16'h0000;
            head_word_q   <= 16'h0000;
            head_addr_q   <= 16'h0000;
`ifdef FETCH_PREFETCH_EN
            tail_word_q   <= 16'h0000;
            tail_addr_q   <= 16'h0000;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            count_q       <= count_d;
            req_q         <= req_d;
            req_addr_q    <= req_addr_d;
            head_word_q   <= head_word_d;
            head_addr_q   <= head_addr_d;
`ifdef FETCH_PREFETCH_EN
            tail_word_q   <= tail_word_d;
            tail_addr_q   <= tail_addr_d;
`endif
        end
    end

    assign memory_read_request         = req_q;
    assign memory_address              = req_addr_q;
    assign instruction_valid           = (count_q != 2'd0);
    assign instruction_operation       = head_word_q[15:12];
    assign instruction_destination     = head_word_q[11:8];
    assign instruction_operation_extra = head_word_q[7:4];
    assign instruction_source          = head_word_q[3:0];
    assign instruction_immediate       = head_word_q[7:0];
    assign instruction_address         = head_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction memory.
// Works in both builds (FETCH_PREFETCH_EN defined or not).
module tb_instruction_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int          DEPTH       = 2;
  localparam logic        EXP13_VALID = 1'b1;
  localparam logic [15:0] EXP13_ADDR  = 16'h0001;
  localparam logic [15:0] EXP14_ADDR  = 16'h0002;
`else
  localparam int          DEPTH       = 1;
  localparam logic        EXP13_VALID = 1'b0;
  localparam logic [15:0] EXP13_ADDR  = 16'h0000;
  localparam logic [15:0] EXP14_ADDR  = 16'h0001;
`endif

  logic        clock;
  logic        reset;
  logic        memory_read_request;
  logic [15:0] memory_address;
  logic        memory_read_valid;
  logic [15:0] memory_read_data;
  logic        instruction_valid;
  logic        instruction_take;
  logic [3:0]  instruction_operation;
  logic [3:0]  instruction_destination;
  logic [3:0]  instruction_operation_extra;
  logic [3:0]  instruction_source;
  logic [7:0]  instruction_immediate;
  logic [15:0] instruction_address;
  logic        redirect;
  logic [15:0] redirect_address;

  int nvec = 0;
  int nerr = 0;

  instruction_fetch_unit #(.RESET_ADDRESS(16'h0000)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .memory_read_request         (memory_read_request),
    .memory_address              (memory_address),
    .memory_read_valid           (memory_read_valid),
    .memory_read_data            (memory_read_data),
    .instruction_valid           (instruction_valid),
    .instruction_take            (instruction_take),
    .instruction_operation       (instruction_operation),
    .instruction_destination     (instruction_destination),
    .instruction_operation_extra (instruction_operation_extra),
    .instruction_source          (instruction_source),
    .instruction_immediate       (instruction_immediate),
    .instruction_address         (instruction_address),
    .redirect                    (redirect),
    .redirect_address            (redirect_address)
  );

  logic [15:0] head;
  assign head = {instruction_operation, instruction_destination,
                 instruction_operation_extra, instruction_source};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h5312 + a;
  endfunction

  int          lat = 1;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  int          wait_n = 0;
  int          nreq = 0;
  logic [15:0] req_log [$];

  initial begin
    memory_read_valid = 1'b0;
    memory_read_data  = 16'h0;
  end

  always begin
    @(posedge clock);
    #1;
    memory_read_valid = 1'b0;
    if (pend) begin
      wait_n--;
      if (wait_n <= 0) begin
        memory_read_valid = 1'b1;
        memory_read_data  = mem_word(pend_addr);
        pend = 1'b0;
      end
    end
    if (memory_read_request) begin
      pend      = 1'b1;
      pend_addr = memory_address;
      wait_n    = lat;
      nreq++;
      req_log.push_back(memory_address);
    end
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  logic        found;
  int          base;
  int          got;
  logic [15:0] haddr [2];
  logic [15:0] hword [2];

  initial begin
    reset            = 1'b1;
    instruction_take = 1'b0;
    redirect         = 1'b0;
    redirect_address = 16'h0;
    haddr[0] = 16'h0; haddr[1] = 16'h0;
    hword[0] = 16'h0; hword[1] = 16'h0;

    repeat (3) tick;
    check("rst req", memory_read_request === 1'b0,
          memory_read_request, 1'b0);
    check("rst maddr", memory_address === 16'h0000,
          memory_address, 16'h0000);
    check("rst valid", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    check("rst fields", head === 16'h0000, head, 16'h0000);
    check("rst imm", instruction_immediate === 8'h00,
          instruction_immediate, 8'h00);
    check("rst iaddr", instruction_address === 16'h0000,
          instruction_address, 16'h0000);

    reset = 1'b0;
    tick;
    check("c1 req", memory_read_request === 1'b1,
          memory_read_request, 1'b1);
    check("c1 maddr", memory_address === 16'h0000,
          memory_address, 16'h0000);
    tick;
    check("c2 valid", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    tick;
    check("c3 valid", instruction_valid === 1'b1,
          instruction_valid, 1'b1);
    check("c3 op", instruction_operation === 4'h5,
          instruction_operation, 4'h5);
    check("c3 dst", instruction_destination === 4'h3,
          instruction_destination, 4'h3);
    check("c3 ext", instruction_operation_extra === 4'h1,
          instruction_operation_extra, 4'h1);
    check("c3 src", instruction_source === 4'h2,
          instruction_source, 4'h2);
    check("c3 imm", instruction_immediate === 8'h12,
          instruction_immediate, 8'h12);
    check("c3 iaddr", instruction_address === 16'h0000,
          instruction_address, 16'h0000);

    repeat (9) tick;
    check("hold nreq", nreq === DEPTH, nreq, DEPTH);
    check("hold last req", req_log[nreq-1] === 16'(DEPTH - 1),
          req_log[nreq-1], 16'(DEPTH - 1));
    check("hold head", head === 16'h5312, head, 16'h5312);
    check("hold valid", instruction_valid === 1'b1,
          instruction_valid, 1'b1);

    instruction_take = 1'b1;
    lat = 4;
    tick;
    check("pop valid", instruction_valid === EXP13_VALID,
          instruction_valid, EXP13_VALID);
    check("pop iaddr", instruction_address === EXP13_ADDR,
          instruction_address, EXP13_ADDR);
    tick;
    check("resume req", memory_read_request === 1'b1,
          memory_read_request, 1'b1);
    check("resume maddr", memory_address === EXP14_ADDR,
          memory_address, EXP14_ADDR);

    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (memory_read_request && memory_address == 16'h0002) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("rd wait req2", found === 1'b1, found, 1'b1);
    redirect = 1'b1;
    redirect_address = 16'h0040;
    instruction_take = 1'b0;
    tick;
    redirect = 1'b0;
    lat = 1;
    check("rd flush", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (memory_read_request) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("rd wait req", found === 1'b1, found, 1'b1);
    check("rd first maddr", memory_address === 16'h0040,
          memory_address, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instruction_valid) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("rd wait head", found === 1'b1, found, 1'b1);
    check("rd head iaddr", instruction_address === 16'h0040,
          instruction_address, 16'h0040);
    check("rd head word", head === 16'h5352, head, 16'h5352);

    instruction_take = 1'b1;
    tick;
    instruction_take = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (memory_read_valid) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("mix wait data", found === 1'b1, found, 1'b1);
    redirect = 1'b1;
    redirect_address = 16'h0100;
    instruction_take = 1'b1;
    tick;
    redirect = 1'b0;
    instruction_take = 1'b0;
    check("mix flush", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instruction_valid) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("mix wait head", found === 1'b1, found, 1'b1);
    check("mix head iaddr", instruction_address === 16'h0100,
          instruction_address, 16'h0100);
    check("mix head word", head === 16'h5412, head, 16'h5412);

    redirect = 1'b1;
    redirect_address = 16'hFFFF;
    base = nreq;
    tick;
    redirect = 1'b0;
    instruction_take = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (instruction_valid) begin
        haddr[got] = instruction_address;
        hword[got] = head;
        got++;
        if (got == 2) break;
      end
      tick;
    end
    instruction_take = 1'b0;
    check("wrap heads", got === 2, got, 2);
    check("wrap req0", req_log[base] === 16'hFFFF,
          req_log[base], 16'hFFFF);
    check("wrap req1", req_log[base+1] === 16'h0000,
          req_log[base+1], 16'h0000);
    check("wrap iaddr0", haddr[0] === 16'hFFFF, haddr[0], 16'hFFFF);
    check("wrap iaddr1", haddr[1] === 16'h0000, haddr[1], 16'h0000);
    check("wrap word0", hword[0] === 16'h5311, hword[0], 16'h5311);
    check("wrap word1", hword[1] === 16'h5312, hword[1], 16'h5312);

    lat = 2;
    instruction_take = 1'b1;
    tick;
    instruction_take = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (memory_read_request) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    check("mrst wait req", found === 1'b1, found, 1'b1);
    reset = 1'b1;
    tick;
    lat = 1;
    check("mrst valid k1", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    check("mrst req k1", memory_read_request === 1'b0,
          memory_read_request, 1'b0);
    tick;
    reset = 1'b0;
    check("mrst valid k2", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    tick;
    check("mrst req k3", memory_read_request === 1'b1,
          memory_read_request, 1'b1);
    check("mrst maddr k3", memory_address === 16'h0000,
          memory_address, 16'h0000);
    check("mrst valid k3", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    tick;
    check("mrst valid k4", instruction_valid === 1'b0,
          instruction_valid, 1'b0);
    tick;
    check("mrst valid k5", instruction_valid === 1'b1,
          instruction_valid, 1'b1);
    check("mrst iaddr k5", instruction_address === 16'h0000,
          instruction_address, 16'h0000);
    check("mrst word k5", head === 16'h5312, head, 16'h5312);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
